// File: rtl/adc_conv_sched.sv
`default_nettype none
// ============================================================================
// adc_conv_sched : round-robin ADC conversion scheduler with wake-up and
//                  idle power-down, clocked in the 200 kHz ADC domain.
// Revision 1.0
// ============================================================================
module adc_conv_sched #(
    parameter int NUM_REQ      = 4,
    parameter int ID_W         = 2,
    parameter int DATA_W       = 12,
    parameter int WAKE_CYCLES  = 20,
    parameter int IDLE_TIMEOUT = 64,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic               clk_200kHz,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic               PD,
    output logic               ADC_ready,
    output logic               convst,
    output logic [ID_W-1:0]    ch_sel,
    input  logic               adc_busy,
    input  logic [DATA_W-1:0]  adc_data,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    output logic [ID_W-1:0]    done_id,
    output logic               busy_err
);

    localparam int C_MAX_AB  = (WAKE_CYCLES > IDLE_TIMEOUT) ? WAKE_CYCLES : IDLE_TIMEOUT;
    localparam int C_CNT_MAX = (C_MAX_AB > BUSY_TIMEOUT) ? C_MAX_AB : BUSY_TIMEOUT;
    localparam int C_CNT_W   = $clog2(C_CNT_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_WAKE_LAST = C_CNT_W'(WAKE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_IDLE_LAST = C_CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [C_CNT_W-1:0] C_BUSY_LAST = C_CNT_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_PD     = 3'd0,
        S_WAKE   = 3'd1,
        S_IDLE   = 3'd2,
        S_START  = 3'd3,
        S_SETTLE = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [C_CNT_W-1:0]  r_cnt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_ch_sel;
    logic [DATA_W-1:0]   r_dout;
    logic                r_dout_valid;
    logic [ID_W-1:0]     r_done_id;
    logic                r_busy_err;

    logic                w_found;
    logic [ID_W-1:0]     w_grant;
    int                  w_dist;
    int                  w_best;
    logic                w_grant_en;
    logic                w_capture;
    logic                w_timeout;

    // Round-robin: each requester's distance from the slot after the pointer;
    // the nearest active one wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_best  = NUM_REQ;
        w_dist  = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j > int'(r_ptr)) begin
                w_dist = j - int'(r_ptr) - 1;
            end else begin
                w_dist = j + NUM_REQ - int'(r_ptr) - 1;
            end
            if (req[j] && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_found = 1'b1;
                w_grant = ID_W'(j);
            end
        end
    end

    always_ff @(posedge clk_200kHz or posedge reset) begin
        if (reset) begin
            r_state <= S_PD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant_en = 1'b0;
        w_capture  = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            S_PD: begin
                if (|req) begin
                    w_next = S_WAKE;
                end
            end
            S_WAKE: begin
                if (r_cnt == C_WAKE_LAST) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                // A request on the timeout clock takes priority over power-down.
                if (w_found) begin
                    w_next     = S_START;
                    w_grant_en = 1'b1;
                end else if (r_cnt == C_IDLE_LAST) begin
                    w_next = S_PD;
                end
            end
            S_START: begin
                w_next = S_SETTLE;
            end
            S_SETTLE: begin
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (!adc_busy) begin
                    w_capture = 1'b1;
                    w_next    = S_IDLE;
                end else if (r_cnt == C_BUSY_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: begin
                w_next = S_PD;
            end
        endcase
    end

    // One shared counter serves wake, idle and busy timing; it restarts on
    // every state change.
    always_ff @(posedge clk_200kHz or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_ptr        <= ID_W'(NUM_REQ - 1);
            r_ch_sel     <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_done_id    <= '0;
            r_busy_err   <= 1'b0;
        end else begin
            if (w_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state != S_PD) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_grant_en) begin
                r_ch_sel <= w_grant;
                r_ptr    <= w_grant;
            end

            r_dout_valid <= w_capture;
            r_busy_err   <= w_timeout;

            if (w_capture) begin
                r_dout <= adc_data;
            end
            if (w_capture || w_timeout) begin
                r_done_id <= r_ch_sel;
            end
        end
    end

    assign PD         = (r_state == S_PD);
    assign ADC_ready  = (r_state == S_IDLE);
    assign convst     = (r_state == S_START);
    assign ch_sel     = r_ch_sel;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign done_id    = r_done_id;
    assign busy_err   = r_busy_err;

endmodule

`default_nettype wire

// File: tb/tb_adc_conv_sched.sv
`default_nettype none
// ============================================================================
// tb_adc_conv_sched : directed bench with a transaction-level reference model
// Revision 1.0
// ============================================================================
module tb_adc_conv_sched;

    localparam int NUM_REQ      = 4;
    localparam int ID_W         = 2;
    localparam int DATA_W       = 12;
    localparam int WAKE_CYCLES  = 20;
    localparam int IDLE_TIMEOUT = 64;
    localparam int BUSY_TIMEOUT = 16;

    localparam int M_PD   = 0;
    localparam int M_WAKE = 1;
    localparam int M_IDLE = 2;
    localparam int M_CONV = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req;
    logic               PD;
    logic               ADC_ready;
    logic               convst;
    logic [ID_W-1:0]    ch_sel;
    logic               adc_busy = 1'b0;
    logic [DATA_W-1:0]  adc_data = '0;
    logic [DATA_W-1:0]  dout;
    logic               dout_valid;
    logic [ID_W-1:0]    done_id;
    logic               busy_err;

    int checks   = 0;
    int failures = 0;

    int                busy_len  = 0;
    int                adc_cnt   = 0;
    logic              adc_kill  = 1'b0;
    logic [DATA_W-1:0] next_data = '0;

    int                m_mode;
    int                m_t;
    int                m_ptr;
    int                m_ch;
    int                m_done;
    logic [DATA_W-1:0] m_dout;
    logic              m_valid;
    logic              m_err;

    adc_conv_sched #(
        .NUM_REQ      (NUM_REQ),
        .ID_W         (ID_W),
        .DATA_W       (DATA_W),
        .WAKE_CYCLES  (WAKE_CYCLES),
        .IDLE_TIMEOUT (IDLE_TIMEOUT),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk_200kHz (clk),
        .reset      (reset),
        .req        (req),
        .PD         (PD),
        .ADC_ready  (ADC_ready),
        .convst     (convst),
        .ch_sel     (ch_sel),
        .adc_busy   (adc_busy),
        .adc_data   (adc_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .done_id    (done_id),
        .busy_err   (busy_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic sel_out(input int which);
        case (which)
            0:       return convst;
            1:       return dout_valid;
            2:       return busy_err;
            3:       return ADC_ready;
            default: return PD;
        endcase
    endfunction

    task automatic wait_sig(input int which, input int limit, output int n);
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (sel_out(which)) begin
                n = i;
                return;
            end
        end
        n = -1;
        checks++;
        failures++;
        $display("FAIL wait_sig%0d: no event within %0d cycles", which, limit);
    endtask

    function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int ptr);
        int idx;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (ptr + k) % NUM_REQ;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    // ADC: after a sampled convst, busy stays high through settle plus
    // busy_len wait clocks, then drops with next_data on the bus.
    always @(posedge clk) begin
        if (reset || adc_kill) begin
            adc_busy <= 1'b0;
            adc_cnt  <= 0;
        end else if (adc_cnt > 0) begin
            adc_cnt <= adc_cnt - 1;
            if (adc_cnt == 1) adc_busy <= 1'b0;
        end else if (convst) begin
            adc_busy <= 1'b1;
            adc_cnt  <= busy_len + 1;
            adc_data <= next_data;
        end
    end

    // Reference model: power mode plus elapsed clocks in that mode.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode  <= M_PD;
            m_t     <= 0;
            m_ptr   <= NUM_REQ - 1;
            m_ch    <= 0;
            m_done  <= 0;
            m_dout  <= '0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            case (m_mode)
                M_PD: begin
                    if (req != 0) begin
                        m_mode <= M_WAKE;
                        m_t    <= 0;
                    end
                end
                M_WAKE: begin
                    if (m_t + 1 == WAKE_CYCLES) begin
                        m_mode <= M_IDLE;
                        m_t    <= 0;
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
                M_IDLE: begin
                    if (req != 0) begin
                        m_ch   <= rr_pick(req, m_ptr);
                        m_ptr  <= rr_pick(req, m_ptr);
                        m_mode <= M_CONV;
                        m_t    <= 0;
                    end else if (m_t + 1 == IDLE_TIMEOUT) begin
                        m_mode <= M_PD;
                        m_t    <= 0;
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
                default: begin
                    if (m_t < 2) begin
                        m_t <= m_t + 1;
                    end else if (!adc_busy) begin
                        m_dout  <= adc_data;
                        m_done  <= m_ch;
                        m_valid <= 1'b1;
                        m_mode  <= M_IDLE;
                        m_t     <= 0;
                    end else if (m_t - 1 == BUSY_TIMEOUT) begin
                        m_err  <= 1'b1;
                        m_done <= m_ch;
                        m_mode <= M_IDLE;
                        m_t    <= 0;
                    end else begin
                        m_t <= m_t + 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        check("PD",         PD,         32'(m_mode == M_PD));
        check("ADC_ready",  ADC_ready,  32'(m_mode == M_IDLE));
        check("convst",     convst,     32'(m_mode == M_CONV && m_t == 0));
        check("ch_sel",     ch_sel,     m_ch);
        check("dout",       dout,       m_dout);
        check("dout_valid", dout_valid, m_valid);
        check("done_id",    done_id,    m_done);
        check("busy_err",   busy_err,   m_err);
    end

    initial begin
        int n;
        reset = 1'b1;
        req   = 4'b1111;
        repeat (3) @(negedge clk);
        check("rst_PD",     PD,         1);
        check("rst_convst", convst,     0);
        check("rst_ready",  ADC_ready,  0);
        check("rst_chsel",  ch_sel,     0);
        check("rst_valid",  dout_valid, 0);

        // Wake-up and first conversion
        reset     = 1'b0;
        req       = 4'b0001;
        busy_len  = 5;
        next_data = 12'hA5C;
        @(negedge clk);
        check("wake_PD", PD, 0);
        wait_sig(3, 40, n);
        check("wake_len", n, 20);
        wait_sig(0, 5, n);
        check("grant_lat", n, 1);
        check("grant0_ch", ch_sel, 0);
        wait_sig(1, 30, n);
        check("valid_lat",  n,       8);
        check("valid_dout", dout,    12'hA5C);
        check("valid_id",   done_id, 0);
        req = 4'b0000;
        @(negedge clk);
        check("valid_pulse", dout_valid, 0);

        // Stuck busy, then a normal conversion
        busy_len = 1000;
        req      = 4'b0100;
        wait_sig(0, 5, n);
        check("stuck_ch", ch_sel, 2);
        wait_sig(2, 30, n);
        check("err_lat",  n,       18);
        check("err_id",   done_id, 2);
        check("err_dout", dout,    12'hA5C);
        req       = 4'b0010;
        adc_kill  = 1'b1;
        busy_len  = 2;
        next_data = 12'h3C1;
        @(negedge clk);
        adc_kill = 1'b0;
        check("err_pulse",     busy_err, 0);
        check("post_err_cst",  convst,   1);
        check("post_err_ch",   ch_sel,   1);
        wait_sig(1, 30, n);
        check("post_err_lat",  n,       5);
        check("post_err_dout", dout,    12'h3C1);
        check("post_err_id",   done_id, 1);
        req = 4'b0000;

        // Idle timeout, then a request on the final idle clock
        wait_sig(4, 80, n);
        check("idle_to",    n,         64);
        check("idle_ready", ADC_ready, 0);
        req = 4'b0001;
        @(negedge clk);
        req = 4'b0000;
        check("wake2_PD", PD, 0);
        wait_sig(3, 40, n);
        check("wake2_len", n, 20);
        repeat (63) @(negedge clk);
        req       = 4'b1000;
        busy_len  = 0;
        next_data = 12'h7E1;
        @(negedge clk);
        check("late_convst", convst, 1);
        check("late_PD",     PD,     0);
        check("late_ch",     ch_sel, 3);
        wait_sig(1, 10, n);
        check("late_lat",  n,    3);
        check("late_dout", dout, 12'h7E1);
        req = 4'b0000;

        // Asynchronous reset during the busy wait
        req      = 4'b0100;
        busy_len = 1000;
        wait_sig(0, 5, n);
        check("pre_rst_ch", ch_sel, 2);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_PD",     PD,         1);
        check("arst_ready",  ADC_ready,  0);
        check("arst_convst", convst,     0);
        check("arst_chsel",  ch_sel,     0);
        check("arst_dout",   dout,       0);
        check("arst_valid",  dout_valid, 0);
        check("arst_doneid", done_id,    0);
        check("arst_err",    busy_err,   0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        req      = 4'b1111;
        busy_len = 1;

        // All requesters held: grants rotate from requester 0
        for (int i = 0; i < 8; i++) begin
            wait_sig(0, 60, n);
            check("rr_order", ch_sel, i % 4);
            next_data = 12'(12'h100 + i);
            if (i == 7) req = 4'b0000;
        end
        wait_sig(1, 20, n);
        check("rr_last_dout", dout,    12'h107);
        check("rr_last_id",   done_id, 3);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
